pulsador_eventos: RTL and testbench



---
 rtl/pulsador_eventos.sv | 122 ++++++++++++
 tb/tb_pulsador_eventos.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulsador_eventos.sv
// Turns the debounced button level into one-cycle press/release/long/repeat events on reloja.
// pulso arrives 2 edges after arebote is first sampled; every event output is registered.
module pulsador_eventos #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LARGO_MS  = 1000,
  parameter int unsigned REPITE_MS = 200,
  parameter int unsigned CW        = 16
) (
  input  logic reloja,
  input  logic reset,
  input  logic arebote,
  output logic presionado,
  output logic pulso,
  output logic suelta,
  output logic largo,
  output logic repite
);

  typedef enum logic [1:0] {LIBRE, PRESION, SOSTENIDO} estado_t;

  localparam logic [CW-1:0] PRE_FIN    = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LARGO_FIN  = CW'(LARGO_MS - 1);
  localparam logic [CW-1:0] REPITE_FIN = CW'(REPITE_MS - 1);

  logic          s1, s2, s3;
  logic          rise, fall;
  estado_t       estado, estado_d;
  logic [CW-1:0] presc, presc_d;
  logic [CW-1:0] ms, ms_d;
  logic [CW-1:0] umbral;
  logic          tick;
  logic          pulso_d, suelta_d, largo_d, repite_d;

  // arebote comes from a divided clock domain, hence the two-flop synchronizer plus edge flop
  always_ff @(posedge reloja or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= arebote;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign presionado = s2;
  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign tick       = (presc == PRE_FIN);

  always_ff @(posedge reloja or posedge reset) begin
    if (reset) begin
      estado <= LIBRE;
      presc  <= '0;
      ms     <= '0;
      pulso  <= 1'b0;
      suelta <= 1'b0;
      largo  <= 1'b0;
      repite <= 1'b0;
    end else begin
      estado <= estado_d;
      presc  <= presc_d;
      ms     <= ms_d;
      pulso  <= pulso_d;
      suelta <= suelta_d;
      largo  <= largo_d;
      repite <= repite_d;
    end
  end

  always_comb begin
    estado_d = estado;
    presc_d  = presc;
    ms_d     = ms;
    pulso_d  = 1'b0;
    suelta_d = 1'b0;
    largo_d  = 1'b0;
    repite_d = 1'b0;
    umbral   = (estado == PRESION) ? LARGO_FIN : REPITE_FIN;
    case (estado)
      LIBRE: begin
        if (rise) begin
          pulso_d  = 1'b1;
          presc_d  = '0;
          ms_d     = '0;
          estado_d = PRESION;
        end
      end
      PRESION, SOSTENIDO: begin
        // release takes priority over a threshold landing in the same cycle
        if (fall) begin
          suelta_d = 1'b1;
          presc_d  = '0;
          ms_d     = '0;
          estado_d = LIBRE;
        end else if (tick) begin
          presc_d = '0;
          if (ms == umbral) begin
            ms_d = '0;
            if (estado == PRESION) begin
              largo_d  = 1'b1;
              estado_d = SOSTENIDO;
            end else begin
              repite_d = 1'b1;
            end
          end else begin
            ms_d = ms + CW'(1);
          end
        end else begin
          presc_d = presc + CW'(1);
        end
      end
      default: begin
        estado_d = LIBRE;
        presc_d  = '0;
        ms_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulsador_eventos.sv
// Directed bench: small-parameter instance for event timing, second instance for long-press distance.
module tb_pulsador_eventos;

  logic reloja, reset;
  logic arebote, presionado, pulso, suelta, largo, repite;
  logic arebote2, presionado2, pulso2, suelta2, largo2, repite2;

  int checks, errors, ciclo;
  int n_pulso, n_suelta, n_largo, n_repite, n_excl;
  int t_pulso, t_suelta, t_largo;
  int t_rep [4];
  int n_pulso2, n_suelta2, n_largo2, n_repite2;
  int t_pulso2, t_suelta2, t_largo2, t_rep2;

  pulsador_eventos #(.TICK_DIV(4), .LARGO_MS(3), .REPITE_MS(2), .CW(16)) dut (
    .reloja(reloja), .reset(reset), .arebote(arebote), .presionado(presionado),
    .pulso(pulso), .suelta(suelta), .largo(largo), .repite(repite)
  );

  pulsador_eventos #(.TICK_DIV(50), .LARGO_MS(20), .REPITE_MS(3), .CW(16)) dut2 (
    .reloja(reloja), .reset(reset), .arebote(arebote2), .presionado(presionado2),
    .pulso(pulso2), .suelta(suelta2), .largo(largo2), .repite(repite2)
  );

  initial begin
    reloja = 1'b0;
    forever #5 reloja = ~reloja;
  end

  always @(posedge reloja) ciclo++;

  // event log: each time is the number of the rising edge after which the output was high
  always @(negedge reloja) begin
    if (pulso)  begin n_pulso++;  t_pulso  = ciclo; end
    if (suelta) begin n_suelta++; t_suelta = ciclo; end
    if (largo)  begin n_largo++;  t_largo  = ciclo; end
    if (repite) begin
      if (n_repite < 4) t_rep[n_repite] = ciclo;
      n_repite++;
    end
    if ((int'(pulso) + int'(largo) + int'(repite) > 1) || (suelta && (pulso || largo || repite)))
      n_excl++;
    if (pulso2)  begin n_pulso2++;  t_pulso2  = ciclo; end
    if (suelta2) begin n_suelta2++; t_suelta2 = ciclo; end
    if (largo2)  begin n_largo2++;  t_largo2  = ciclo; end
    if (repite2) begin n_repite2++; t_rep2    = ciclo; end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge reloja);
    #1;
  endtask

  task automatic limpia;
    n_pulso = 0; n_suelta = 0; n_largo = 0; n_repite = 0;
    t_pulso = -1; t_suelta = -1; t_largo = -1;
    for (int i = 0; i < 4; i++) t_rep[i] = -1;
    n_pulso2 = 0; n_suelta2 = 0; n_largo2 = 0; n_repite2 = 0;
    t_pulso2 = -1; t_suelta2 = -1; t_largo2 = -1; t_rep2 = -1;
  endtask

  task automatic test_reset;
    int malos;
    reset = 1'b1; arebote = 1'b0; arebote2 = 1'b0;
    ciclos(3);
    checks++;
    if ({presionado, pulso, suelta, largo, repite} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {presionado, pulso, suelta, largo, repite});
    end
    reset = 1'b0;
    malos = 0;
    for (int i = 0; i < 100; i++) begin
      ciclos(1);
      if ({presionado, pulso, suelta, largo, repite, presionado2, pulso2, suelta2, largo2, repite2} !== 10'b0)
        malos++;
    end
    checks++;
    if (malos !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", malos); end
  endtask

  task automatic test_tap;
    int n;
    limpia;
    arebote = 1'b1; n = ciclo + 1;
    ciclos(5);
    arebote = 1'b0;
    ciclos(10);
    checks++;
    if (n_pulso !== 1 || t_pulso !== n + 2) begin
      errors++; $display("FAIL tap_pulso: got count %0d edge %0d want 1 edge %0d", n_pulso, t_pulso, n + 2);
    end
    checks++;
    if (n_suelta !== 1 || t_suelta !== n + 7) begin
      errors++; $display("FAIL tap_suelta: got count %0d edge %0d want 1 edge %0d", n_suelta, t_suelta, n + 7);
    end
    checks++;
    if (n_largo !== 0 || n_repite !== 0) begin
      errors++; $display("FAIL tap_no_largo: got largo %0d repite %0d want 0 0", n_largo, n_repite);
    end
  endtask

  // 34 sampled-high cycles: release lands at P+34, after repites at P+20/P+28 and before P+36
  task automatic test_hold;
    int n, p;
    limpia;
    arebote = 1'b1; n = ciclo + 1; p = n + 2;
    ciclos(34);
    arebote = 1'b0;
    ciclos(8);
    checks++;
    if (n_pulso !== 1 || t_pulso !== p) begin
      errors++; $display("FAIL hold_pulso: got count %0d edge %0d want 1 edge %0d", n_pulso, t_pulso, p);
    end
    checks++;
    if (n_largo !== 1 || t_largo !== p + 12) begin
      errors++; $display("FAIL hold_largo: got count %0d edge %0d want 1 edge %0d", n_largo, t_largo, p + 12);
    end
    checks++;
    if (n_repite !== 2 || t_rep[0] !== p + 20 || t_rep[1] !== p + 28) begin
      errors++; $display("FAIL hold_repite: got count %0d edges %0d %0d want 2 edges %0d %0d",
                         n_repite, t_rep[0], t_rep[1], p + 20, p + 28);
    end
    checks++;
    if (n_suelta !== 1 || t_suelta !== p + 34) begin
      errors++; $display("FAIL hold_suelta: got count %0d edge %0d want 1 edge %0d", n_suelta, t_suelta, p + 34);
    end
  endtask

  task automatic test_release_wins;
    int n, p;
    limpia;
    arebote = 1'b1; n = ciclo + 1; p = n + 2;
    ciclos(12);
    arebote = 1'b0;
    ciclos(8);
    checks++;
    if (n_suelta !== 1 || t_suelta !== p + 12) begin
      errors++; $display("FAIL coincide_suelta: got count %0d edge %0d want 1 edge %0d", n_suelta, t_suelta, p + 12);
    end
    checks++;
    if (n_largo !== 0) begin errors++; $display("FAIL coincide_largo: got %0d want 0", n_largo); end
  endtask

  task automatic test_reset_mid;
    int r;
    limpia;
    arebote = 1'b1;
    ciclos(20);
    checks++;
    if (n_largo !== 1) begin errors++; $display("FAIL mid_reach_sostenido: got largo %0d want 1", n_largo); end
    reset = 1'b1;
    #1;
    checks++;
    if (presionado !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %b want 0", presionado); end
    ciclos(2);
    limpia;
    reset = 1'b0; r = ciclo;
    ciclos(16);
    checks++;
    if (n_suelta !== 0) begin errors++; $display("FAIL mid_no_suelta: got %0d want 0", n_suelta); end
    checks++;
    if (n_pulso !== 1 || t_pulso !== r + 3) begin
      errors++; $display("FAIL mid_pulso: got count %0d edge %0d want 1 edge %0d", n_pulso, t_pulso, r + 3);
    end
    checks++;
    if (n_largo !== 1 || t_largo !== r + 15) begin
      errors++; $display("FAIL mid_largo: got count %0d edge %0d want 1 edge %0d", n_largo, t_largo, r + 15);
    end
    arebote = 1'b0;
    ciclos(6);
    checks++;
    if (n_suelta !== 1) begin errors++; $display("FAIL mid_release: got %0d want 1", n_suelta); end
  endtask

  // sub-cycle glitch straddling a rising edge, then a short tap right behind it
  task automatic test_back_to_back;
    int n;
    limpia;
    ciclos(1);
    #2 arebote = 1'b1; n = ciclo + 1;
    @(posedge reloja);
    #2 arebote = 1'b0;
    ciclos(8);
    checks++;
    if (n_pulso !== 1 || t_pulso !== n + 2 || n_suelta !== 1 || t_suelta !== n + 3) begin
      errors++; $display("FAIL glitch_events: got pulso %0d@%0d suelta %0d@%0d want 1@%0d 1@%0d",
                         n_pulso, t_pulso, n_suelta, t_suelta, n + 2, n + 3);
    end
    arebote = 1'b1; n = ciclo + 1;
    ciclos(2);
    arebote = 1'b0;
    ciclos(8);
    checks++;
    if (n_pulso !== 2 || t_pulso !== n + 2 || n_suelta !== 2 || t_suelta !== n + 4) begin
      errors++; $display("FAIL after_glitch_tap: got pulso %0d@%0d suelta %0d@%0d want 2@%0d 2@%0d",
                         n_pulso, t_pulso, n_suelta, t_suelta, n + 2, n + 4);
    end
    checks++;
    if (n_excl !== 0) begin errors++; $display("FAIL exclusivity: got %0d overlaps want 0", n_excl); end
  endtask

  task automatic test_long_params;
    int n;
    limpia;
    arebote2 = 1'b1; n = ciclo + 1;
    ciclos(1200);
    checks++;
    if (n_pulso2 !== 1 || t_pulso2 !== n + 2) begin
      errors++; $display("FAIL long_pulso: got count %0d edge %0d want 1 edge %0d", n_pulso2, t_pulso2, n + 2);
    end
    checks++;
    if (n_largo2 !== 1 || t_largo2 - t_pulso2 !== 1000) begin
      errors++; $display("FAIL long_largo: got count %0d distance %0d want 1 distance 1000",
                         n_largo2, t_largo2 - t_pulso2);
    end
    checks++;
    if (n_repite2 !== 1 || t_rep2 - t_largo2 !== 150) begin
      errors++; $display("FAIL long_repite: got count %0d distance %0d want 1 distance 150",
                         n_repite2, t_rep2 - t_largo2);
    end
    arebote2 = 1'b0;
    ciclos(5);
    checks++;
    if (n_suelta2 !== 1 || t_suelta2 !== n + 1202) begin
      errors++; $display("FAIL long_suelta: got count %0d edge %0d want 1 edge %0d", n_suelta2, t_suelta2, n + 1202);
    end
  endtask

  initial begin
    checks = 0; errors = 0; ciclo = 0; n_excl = 0;
    reset = 1'b1; arebote = 1'b0; arebote2 = 1'b0;
    limpia;
    test_reset;
    test_tap;
    test_hold;
    test_release_wins;
    test_reset_mid;
    test_back_to_back;
    test_long_params;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
